// File: rtl/freq_mac.sv
// freq_mac: multiplies each 2D-FFT spectral beat lane-wise by a stored kernel spectrum
// and accumulates the products over input channels, then drains one tile of results.
module freq_mac #(
  parameter int DATALEN = 16,
  parameter int LANES   = 16,
  parameter int BEATS   = 4,
  parameter int MAXCH   = 8,
  localparam int ACCLEN = 2*DATALEN + 1 + $clog2(MAXCH),
  localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [3:0]                   cfg_nchan,
  input  logic                         coef_we,
  input  logic [BW-1:0]                coef_addr,
  input  logic [LANES*2*DATALEN-1:0]   coef_data,
  input  logic                         in_valid,
  input  logic [LANES*2*DATALEN-1:0]   in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES*2*ACCLEN-1:0]    out_data,
  output logic                         out_last
);

  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [3:0]    NCH_MAX   = (MAXCH > 15) ? 4'd15 : 4'(MAXCH);

  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, DRAIN} state_t;

  function automatic logic signed [2*DATALEN-1:0] smul(input logic signed [DATALEN-1:0] a,
                                                       input logic signed [DATALEN-1:0] b);
    logic signed [2*DATALEN-1:0] ae, be;
    ae = {{DATALEN{a[DATALEN-1]}}, a};
    be = {{DATALEN{b[DATALEN-1]}}, b};
    return ae * be;
  endfunction

  function automatic logic signed [ACCLEN-1:0] widen(input logic signed [2*DATALEN-1:0] v);
    return {{(ACCLEN-2*DATALEN){v[2*DATALEN-1]}}, v};
  endfunction

  function automatic logic [3:0] clamp_nch(input logic [3:0] n);
    if (n == 4'd0)   return 4'd1;
    if (n > NCH_MAX) return NCH_MAX;
    return n;
  endfunction

  state_t          state, state_nxt;
  logic [BW-1:0]   beat_cnt, rd_cnt, cur_beat;
  logic [3:0]      chan_cnt, nch, cur_chan, cur_nch;
  logic [1:0]      flush_cnt;
  logic            accept, last_in, drain_hs, drain_last;

  logic signed [DATALEN-1:0] xr [LANES];
  logic signed [DATALEN-1:0] xi [LANES];
  logic signed [DATALEN-1:0] coef_re [BEATS][LANES];
  logic signed [DATALEN-1:0] coef_im [BEATS][LANES];

  logic signed [2*DATALEN-1:0] mrr_p0 [LANES];
  logic signed [2*DATALEN-1:0] mii_p0 [LANES];
  logic signed [2*DATALEN-1:0] mri_p0 [LANES];
  logic signed [2*DATALEN-1:0] mir_p0 [LANES];
  logic signed [ACCLEN-1:0]    re_p1  [LANES];
  logic signed [ACCLEN-1:0]    im_p1  [LANES];
  logic signed [ACCLEN-1:0]    acc_re [BEATS][LANES];
  logic signed [ACCLEN-1:0]    acc_im [BEATS][LANES];
  logic                        vld_p0, vld_p1;
  logic [BW-1:0]               beat_p0, beat_p1;
  logic [3:0]                  chan_p0, chan_p1;

  assign in_ready   = (state == IDLE) || (state == ACCUM);
  assign out_valid  = (state == DRAIN);
  assign out_last   = out_valid && (rd_cnt == LAST_BEAT);
  assign accept     = in_valid && in_ready;
  assign cur_beat   = (state == IDLE) ? '0 : beat_cnt;
  assign cur_chan   = (state == IDLE) ? 4'd0 : chan_cnt;
  assign cur_nch    = (state == IDLE) ? clamp_nch(cfg_nchan) : nch;
  assign last_in    = accept && (cur_beat == LAST_BEAT) && (cur_chan == cur_nch - 4'd1);
  assign drain_hs   = out_valid && out_ready;
  assign drain_last = drain_hs && (rd_cnt == LAST_BEAT);

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      xr[k] = in_data[2*k*DATALEN +: DATALEN];
      xi[k] = in_data[(2*k+1)*DATALEN +: DATALEN];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = last_in ? FLUSH : ACCUM;
      ACCUM:   if (last_in) state_nxt = FLUSH;
      FLUSH:   if (flush_cnt == 2'd2) state_nxt = DRAIN;
      DRAIN:   if (drain_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      beat_cnt  <= '0;
      chan_cnt  <= 4'd0;
      rd_cnt    <= '0;
      flush_cnt <= 2'd0;
      nch       <= 4'd1;
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
    end else begin
      vld_p0 <= accept;
      vld_p1 <= vld_p0;
      if (accept) begin
        if (state == IDLE) nch <= clamp_nch(cfg_nchan);
        if (cur_beat == LAST_BEAT) begin
          beat_cnt <= '0;
          chan_cnt <= cur_chan + 4'd1;
        end else begin
          beat_cnt <= cur_beat + 1'b1;
          chan_cnt <= cur_chan;
        end
      end
      flush_cnt <= (state == FLUSH) ? flush_cnt + 2'd1 : 2'd0;
      if (state == FLUSH)  rd_cnt <= '0;
      else if (drain_hs)   rd_cnt <= drain_last ? '0 : rd_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (coef_we && state == IDLE) begin
      for (int k = 0; k < LANES; k++) begin
        coef_re[coef_addr][k] <= coef_data[2*k*DATALEN +: DATALEN];
        coef_im[coef_addr][k] <= coef_data[(2*k+1)*DATALEN +: DATALEN];
      end
    end
  end

  always_ff @(posedge clk) begin
    // p0: partial products, tagged with beat and channel
    beat_p0 <= cur_beat;
    chan_p0 <= cur_chan;
    for (int k = 0; k < LANES; k++) begin
      mrr_p0[k] <= smul(xr[k], coef_re[cur_beat][k]);
      mii_p0[k] <= smul(xi[k], coef_im[cur_beat][k]);
      mri_p0[k] <= smul(xr[k], coef_im[cur_beat][k]);
      mir_p0[k] <= smul(xi[k], coef_re[cur_beat][k]);
    end
    // p1: complex product at accumulator width
    beat_p1 <= beat_p0;
    chan_p1 <= chan_p0;
    for (int k = 0; k < LANES; k++) begin
      re_p1[k] <= widen(mrr_p0[k]) - widen(mii_p0[k]);
      im_p1[k] <= widen(mri_p0[k]) + widen(mir_p0[k]);
    end
    // accumulate: channel 0 overwrites so no clear is needed between tiles
    if (vld_p1) begin
      for (int k = 0; k < LANES; k++) begin
        acc_re[beat_p1][k] <= (chan_p1 == 4'd0) ? re_p1[k] : acc_re[beat_p1][k] + re_p1[k];
        acc_im[beat_p1][k] <= (chan_p1 == 4'd0) ? im_p1[k] : acc_im[beat_p1][k] + im_p1[k];
      end
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_out
    assign out_data[2*k*ACCLEN +: ACCLEN]     = out_valid ? acc_re[rd_cnt][k] : '0;
    assign out_data[(2*k+1)*ACCLEN +: ACCLEN] = out_valid ? acc_im[rd_cnt][k] : '0;
  end

endmodule

// File: tb/tb_freq_mac.sv
// Directed bench for freq_mac: hand-computed tiles checked lane by lane with immediate assertions.
module tb_freq_mac;
  localparam int D  = 16;
  localparam int L  = 16;
  localparam int A  = 36;
  localparam int IW = L*2*D;
  localparam int OW = L*2*A;
  localparam int LW = 2*A;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    cfg_nchan;
  logic          coef_we;
  logic [1:0]    coef_addr;
  logic [IW-1:0] coef_data;
  logic          in_valid;
  logic [IW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic          out_last;

  int vectors = 0;
  int miscompares = 0;

  freq_mac dut (
    .clk(clk), .reset(reset), .cfg_nchan(cfg_nchan), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_data(coef_data), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [IW-1:0] pk(int r, int i, bit lramp);
    logic [IW-1:0] v;
    v = '0;
    for (int k = 0; k < L; k++) begin
      v[2*k*D +: D]     = 16'(lramp ? r*k : r);
      v[(2*k+1)*D +: D] = 16'(lramp ? i*k : i);
    end
    return v;
  endfunction

  function automatic logic [OW-1:0] pko(longint r, longint i, bit lramp);
    logic [OW-1:0] v;
    v = '0;
    for (int k = 0; k < L; k++) begin
      v[2*k*A +: A]     = A'(lramp ? r*k : r);
      v[(2*k+1)*A +: A] = A'(lramp ? i*k : i);
    end
    return v;
  endfunction

  task automatic chk(string tag, logic [LW-1:0] obs, logic [LW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(string tag, logic obs, logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(string tag, longint er, longint ei, bit lramp);
    logic [OW-1:0] e;
    e = pko(er, ei, lramp);
    for (int k = 0; k < L; k++) chk($sformatf("%s_lane%0d", tag, k), out_data[k*LW +: LW], e[k*LW +: LW]);
  endtask

  task automatic set_coef(int r, int i, bit bramp);
    for (int b = 0; b < 4; b++) begin
      coef_we   = 1'b1;
      coef_addr = 2'(b);
      coef_data = pk(bramp ? r*(b+1) : r, bramp ? i*(b+1) : i, 1'b0);
      @(negedge clk);
    end
    coef_we = 1'b0;
  endtask

  task automatic send(logic [IW-1:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    chk1("send_in_ready", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_tile(int cfg, int nchan, int r, int i, bit lramp, bit chramp, int gap);
    cfg_nchan = 4'(cfg);
    for (int c = 0; c < nchan; c++)
      for (int b = 0; b < 4; b++) begin
        send(pk(chramp ? r*(c+1) : r, chramp ? i*(c+1) : i, lramp));
        if (gap > 0) repeat (gap) @(negedge clk);
      end
  endtask

  task automatic wait_valid(string tag);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    chk1({tag, "_out_valid"}, out_valid, 1'b1);
  endtask

  task automatic drain_check(string tag, longint er, longint ei, bit lramp, bit bramp, int hold);
    out_ready = 1'b1;
    wait_valid(tag);
    for (int b = 0; b < 4; b++) begin
      if (b == hold) begin
        out_ready = 1'b0;
        repeat (5) begin
          chk_beat({tag, "_hold"}, bramp ? er*(b+1) : er, bramp ? ei*(b+1) : ei, lramp);
          chk1({tag, "_hold_in_ready"}, in_ready, 1'b0);
          chk1({tag, "_hold_valid"}, out_valid, 1'b1);
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
      chk_beat($sformatf("%s_b%0d", tag, b), bramp ? er*(b+1) : er, bramp ? ei*(b+1) : ei, lramp);
      chk1($sformatf("%s_last%0d", tag, b), out_last, b == 3);
      @(negedge clk);
    end
    chk1({tag, "_done_valid"}, out_valid, 1'b0);
    chk1({tag, "_done_in_ready"}, in_ready, 1'b1);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; coef_we = 1'b0; coef_addr = '0;
    coef_data = '0; cfg_nchan = 4'd0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_out_last", out_last, 1'b0);
    chk_beat("rst_out_data", 0, 0, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // identity kernel, lane ramp, latency of four cycles
    set_coef(1, 0, 1'b0);
    send_tile(1, 1, 1, -1, 1'b1, 1'b0, 0);
    chk1("lat_in_ready", in_ready, 1'b0);
    chk1("lat_t1", out_valid, 1'b0);
    @(negedge clk); chk1("lat_t2", out_valid, 1'b0);
    @(negedge clk); chk1("lat_t3", out_valid, 1'b0);
    @(negedge clk); chk1("lat_t4", out_valid, 1'b1);
    drain_check("ident", 1, -1, 1'b1, 1'b0, -1);

    // j kernel rotates 3+4j to -4+3j; stall the drain on beat 1
    set_coef(0, 1, 1'b0);
    send_tile(1, 1, 3, 4, 1'b0, 1'b0, 0);
    drain_check("rot", -4, 3, 1'b0, 1'b0, 1);

    // three channels 1,2,3 times 2 -> 12, without and with input gaps
    set_coef(2, 0, 1'b0);
    send_tile(3, 3, 1, 0, 1'b0, 1'b1, 0);
    drain_check("acc3", 12, 0, 1'b0, 1'b0, -1);
    send_tile(3, 3, 1, 0, 1'b0, 1'b1, 2);
    drain_check("acc3gap", 12, 0, 1'b0, 1'b0, -1);

    // cfg_nchan=0 acts as one channel, overwrite of the previous accumulation
    send_tile(0, 1, 5, 0, 1'b0, 1'b0, 0);
    drain_check("ovw", 10, 0, 1'b0, 1'b0, -1);

    // per-beat kernel (b+1)+0j on input 1+1j
    set_coef(1, 0, 1'b1);
    send_tile(1, 1, 1, 1, 1'b0, 1'b0, 0);
    drain_check("beatk", 1, 1, 1'b0, 1'b1, -1);

    // extreme operands over eight channels: 0 + 2^34 j
    set_coef(-32768, -32768, 1'b0);
    send_tile(8, 8, -32768, -32768, 1'b0, 1'b0, 0);
    drain_check("ext", 0, 64'sd17179869184, 1'b0, 1'b0, -1);

    // cfg_nchan=12 clamps to 8 channels
    set_coef(1, 0, 1'b0);
    send_tile(12, 8, 1, 0, 1'b0, 1'b0, 0);
    drain_check("clamp", 8, 0, 1'b0, 1'b0, -1);

    // reset in the middle of accumulation abandons the tile
    cfg_nchan = 4'd2;
    for (int b = 0; b < 3; b++) send(pk(9, 9, 1'b0));
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    chk1("racc_in_ready", in_ready, 1'b1);
    chk1("racc_out_valid", out_valid, 1'b0);
    send_tile(1, 1, 4, 0, 1'b0, 1'b0, 0);
    drain_check("racc", 4, 0, 1'b0, 1'b0, -1);

    // coefficient writes and reset during drain
    set_coef(2, 0, 1'b0);
    send_tile(1, 1, 3, 0, 1'b0, 1'b0, 0);
    out_ready = 1'b1;
    wait_valid("rdr");
    for (int b = 0; b < 2; b++) begin
      chk_beat($sformatf("rdr_b%0d", b), 6, 0, 1'b0);
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk_beat("rdr_b2", 6, 0, 1'b0);
    for (int b = 0; b < 4; b++) begin
      coef_we = 1'b1; coef_addr = 2'(b); coef_data = pk(7, 7, 1'b0);
      @(negedge clk);
    end
    coef_we = 1'b0;
    chk1("rdr_still_valid", out_valid, 1'b1);
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    chk1("rdr_out_valid", out_valid, 1'b0);
    chk1("rdr_out_last", out_last, 1'b0);
    chk1("rdr_in_ready", in_ready, 1'b1);
    chk_beat("rdr_out_data", 0, 0, 1'b0);
    send_tile(1, 1, 5, 0, 1'b0, 1'b0, 0);
    drain_check("rdr_next", 10, 0, 1'b0, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
